wordle_engine: RTL and testbench

- Parametrised successor to the fixed 4-letter word game.
- Word length, guess limit and dictionary size are parameters.
- Letters are 5-bit alphabet indices (A=0 … Z=25), not segment patterns.
- Feedback per position follows true Wordle scoring: exact / present / absent, with correct duplicate-letter accounting.
- Sits between the switch/key input decoder and the seven-segment/LED display driver; the display driver maps indices and feedback to segments and LEDs.

---
 rtl/wordle_pkg.sv | 39 +++
 rtl/wordle_word_rom.sv | 61 ++++++
 rtl/wordle_engine.sv | 223 ++++++++++++++++++++++
 tb/tb_wordle_engine.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wordle_pkg.sv
// Shared types for the word-guessing engine: letter indices, per-position
// feedback codes and the controller state encoding.
package wordle_pkg;

    typedef logic [4:0] letter_t;

    localparam letter_t LETTER_MAX = 5'd25;

    localparam letter_t LETTER_A = 5'd0,  LETTER_B = 5'd1,  LETTER_C = 5'd2,  LETTER_D = 5'd3;
    localparam letter_t LETTER_E = 5'd4,  LETTER_F = 5'd5,  LETTER_G = 5'd6,  LETTER_H = 5'd7;
    localparam letter_t LETTER_I = 5'd8,  LETTER_J = 5'd9,  LETTER_K = 5'd10, LETTER_L = 5'd11;
    localparam letter_t LETTER_M = 5'd12, LETTER_N = 5'd13, LETTER_O = 5'd14, LETTER_P = 5'd15;
    localparam letter_t LETTER_Q = 5'd16, LETTER_R = 5'd17, LETTER_S = 5'd18, LETTER_T = 5'd19;
    localparam letter_t LETTER_U = 5'd20, LETTER_V = 5'd21, LETTER_W = 5'd22, LETTER_X = 5'd23;
    localparam letter_t LETTER_Y = 5'd24, LETTER_Z = 5'd25;

    typedef enum logic [1:0] {
        FB_NONE    = 2'b00,
        FB_ABSENT  = 2'b01,
        FB_PRESENT = 2'b10,
        FB_EXACT   = 2'b11
    } fb_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_SCORE_EXACT,
        S_SCORE_PRESENT,
        S_CHECK,
        S_WIN,
        S_LOSE
    } state_t;

    // Packs a four-letter word with its first letter in the LSBs.
    function automatic logic [19:0] word4(letter_t a, letter_t b, letter_t c, letter_t d);
        return {d, c, b, a};
    endfunction

endpackage

// File: rtl/wordle_word_rom.sv
// Combinational dictionary: index -> packed word (letter 0 in the LSBs).
// Four-letter words come from a fixed list; other lengths use a generated pattern.
module wordle_word_rom
    import wordle_pkg::*;
#(
    parameter int WORD_LEN  = 4,
    parameter int NUM_WORDS = 20
) (
    input  logic [$clog2(NUM_WORDS)-1:0] idx_i,
    output logic [5*WORD_LEN-1:0]        word_o
);

    function automatic logic [5*WORD_LEN-1:0] gen_word(input int idx);
        logic [5*WORD_LEN-1:0] w;
        w = '0;
        for (int p = 0; p < WORD_LEN; p++) begin
            w[5*p +: 5] = 5'((idx * 7 + p * 5 + 1) % 26);
        end
        return w;
    endfunction

    generate
        if (WORD_LEN == 4) begin : g_fixed
            localparam logic [19:0] WORDS [20] = '{
                word4(LETTER_C, LETTER_O, LETTER_D, LETTER_E),
                word4(LETTER_L, LETTER_O, LETTER_V, LETTER_E),
                word4(LETTER_F, LETTER_L, LETTER_I, LETTER_P),
                word4(LETTER_B, LETTER_O, LETTER_O, LETTER_K),
                word4(LETTER_S, LETTER_T, LETTER_A, LETTER_R),
                word4(LETTER_G, LETTER_A, LETTER_M, LETTER_E),
                word4(LETTER_J, LETTER_U, LETTER_M, LETTER_P),
                word4(LETTER_W, LETTER_A, LETTER_V, LETTER_E),
                word4(LETTER_F, LETTER_I, LETTER_S, LETTER_H),
                word4(LETTER_K, LETTER_I, LETTER_N, LETTER_G),
                word4(LETTER_Z, LETTER_E, LETTER_R, LETTER_O),
                word4(LETTER_Q, LETTER_U, LETTER_I, LETTER_Z),
                word4(LETTER_M, LETTER_O, LETTER_O, LETTER_N),
                word4(LETTER_T, LETTER_R, LETTER_E, LETTER_E),
                word4(LETTER_B, LETTER_L, LETTER_U, LETTER_E),
                word4(LETTER_D, LETTER_U, LETTER_C, LETTER_K),
                word4(LETTER_H, LETTER_A, LETTER_L, LETTER_F),
                word4(LETTER_N, LETTER_E, LETTER_S, LETTER_T),
                word4(LETTER_R, LETTER_O, LETTER_C, LETTER_K),
                word4(LETTER_Y, LETTER_A, LETTER_R, LETTER_D)
            };

            always_comb begin
                if (int'(idx_i) < 20) begin
                    word_o = WORDS[idx_i];
                end else begin
                    word_o = gen_word(int'(idx_i));
                end
            end
        end else begin : g_generated
            always_comb begin
                word_o = gen_word(int'(idx_i));
            end
        end
    endgenerate

endmodule

// File: rtl/wordle_engine.sv
// Word-guessing game controller: letter entry, two-pass Wordle scoring with
// duplicate accounting, and win/lose tracking against a ROM-selected secret.
module wordle_engine
    import wordle_pkg::*;
#(
    parameter int WORD_LEN    = 4,
    parameter int MAX_GUESSES = 6,
    parameter int NUM_WORDS   = 20
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enter,
    input  logic [4:0]                      letter_in,
    input  logic                            word_force,
    input  logic [$clog2(NUM_WORDS)-1:0]    word_force_idx,
    output logic [5*WORD_LEN-1:0]           guess_flat,
    output logic [$clog2(WORD_LEN+1)-1:0]   entry_pos,
    output logic [2*WORD_LEN-1:0]           feedback,
    output logic [3:0]                      guess_count,
    output logic                            busy,
    output logic                            bad_letter,
    output logic                            win,
    output logic                            lose,
    output logic [5*WORD_LEN-1:0]           secret_flat
);

    localparam int IW = $clog2(NUM_WORDS);
    localparam int PW = $clog2(WORD_LEN + 1);
    localparam int KW = $clog2(WORD_LEN);

    localparam logic [IW-1:0] SEL_LAST = IW'(NUM_WORDS - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(WORD_LEN - 1);
    localparam logic [PW-1:0] POS_FULL = PW'(WORD_LEN);
    localparam logic [KW-1:0] K_LAST   = KW'(WORD_LEN - 1);
    localparam logic [3:0]    GC_MAX   = 4'(MAX_GUESSES);

    state_t              state_q, state_d;
    logic                enter_q;
    logic [IW-1:0]       sel_cnt_q, sel_cnt_d;
    letter_t             secret_q [WORD_LEN];
    letter_t             secret_d [WORD_LEN];
    letter_t             guess_q  [WORD_LEN];
    letter_t             guess_d  [WORD_LEN];
    fb_t                 fb_q     [WORD_LEN];
    fb_t                 fb_d     [WORD_LEN];
    logic [WORD_LEN-1:0] exact_q, exact_d;
    logic [WORD_LEN-1:0] used_q, used_d;
    logic [KW-1:0]       k_q, k_d;
    logic [PW-1:0]       entry_pos_q, entry_pos_d;
    logic [3:0]          guess_count_q, guess_count_d;
    logic                bad_q, bad_d;

    logic                strobe;
    logic                found;
    logic [IW-1:0]       force_idx;
    logic [IW-1:0]       rom_idx;
    logic [5*WORD_LEN-1:0] rom_word;

    assign strobe    = enter & ~enter_q;
    assign force_idx = IW'(int'(word_force_idx) % NUM_WORDS);
    assign rom_idx   = word_force ? force_idx : sel_cnt_q;

    wordle_word_rom #(
        .WORD_LEN  (WORD_LEN),
        .NUM_WORDS (NUM_WORDS)
    ) u_rom (
        .idx_i  (rom_idx),
        .word_o (rom_word)
    );

    always_comb begin
        state_d       = state_q;
        sel_cnt_d     = (sel_cnt_q == SEL_LAST) ? '0 : sel_cnt_q + IW'(1);
        secret_d      = secret_q;
        guess_d       = guess_q;
        fb_d          = fb_q;
        exact_d       = exact_q;
        used_d        = used_q;
        k_d           = k_q;
        entry_pos_d   = entry_pos_q;
        guess_count_d = guess_count_q;
        bad_d         = 1'b0;
        found         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    for (int i = 0; i < WORD_LEN; i++) begin
                        secret_d[i] = rom_word[5*i +: 5];
                    end
                    guess_d       = '{default: '0};
                    fb_d          = '{default: FB_NONE};
                    entry_pos_d   = '0;
                    guess_count_d = '0;
                    state_d       = S_ENTRY;
                end
            end

            S_ENTRY: begin
                if (strobe) begin
                    if (letter_in <= LETTER_MAX) begin
                        // Previous guess's feedback stays visible until a new guess begins.
                        if (entry_pos_q == '0) begin
                            fb_d = '{default: FB_NONE};
                        end
                        guess_d[entry_pos_q[KW-1:0]] = letter_in;
                        if (entry_pos_q == POS_LAST) begin
                            entry_pos_d = POS_FULL;
                            state_d     = S_SCORE_EXACT;
                        end else begin
                            entry_pos_d = entry_pos_q + PW'(1);
                        end
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end

            S_SCORE_EXACT: begin
                for (int i = 0; i < WORD_LEN; i++) begin
                    exact_d[i] = (guess_q[i] == secret_q[i]);
                end
                used_d  = exact_d;
                k_d     = '0;
                state_d = S_SCORE_PRESENT;
            end

            S_SCORE_PRESENT: begin
                // Each secret letter may justify at most one 'present' mark.
                if (exact_q[k_q]) begin
                    fb_d[k_q] = FB_EXACT;
                end else begin
                    for (int j = 0; j < WORD_LEN; j++) begin
                        if (!found && !used_q[j] && (secret_q[j] == guess_q[k_q])) begin
                            found     = 1'b1;
                            used_d[j] = 1'b1;
                        end
                    end
                    fb_d[k_q] = found ? FB_PRESENT : FB_ABSENT;
                end
                if (k_q == K_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end

            S_CHECK: begin
                guess_count_d = (guess_count_q == 4'hF) ? guess_count_q : guess_count_q + 4'd1;
                if (&exact_q) begin
                    state_d = S_WIN;
                end else if (guess_count_d == GC_MAX) begin
                    state_d = S_LOSE;
                end else begin
                    entry_pos_d = '0;
                    state_d     = S_ENTRY;
                end
            end

            S_WIN, S_LOSE: begin
                if (strobe) begin
                    secret_d      = '{default: '0};
                    guess_d       = '{default: '0};
                    fb_d          = '{default: FB_NONE};
                    entry_pos_d   = '0;
                    guess_count_d = '0;
                    state_d       = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            enter_q       <= 1'b0;
            sel_cnt_q     <= '0;
            secret_q      <= '{default: '0};
            guess_q       <= '{default: '0};
            fb_q          <= '{default: FB_NONE};
            exact_q       <= '0;
            used_q        <= '0;
            k_q           <= '0;
            entry_pos_q   <= '0;
            guess_count_q <= '0;
            bad_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            enter_q       <= enter;
            sel_cnt_q     <= sel_cnt_d;
            secret_q      <= secret_d;
            guess_q       <= guess_d;
            fb_q          <= fb_d;
            exact_q       <= exact_d;
            used_q        <= used_d;
            k_q           <= k_d;
            entry_pos_q   <= entry_pos_d;
            guess_count_q <= guess_count_d;
            bad_q         <= bad_d;
        end
    end

    logic reveal;
    assign reveal = (state_q == S_WIN) || (state_q == S_LOSE);

    generate
        for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_out
            assign guess_flat[5*gi +: 5]  = guess_q[gi];
            assign feedback[2*gi +: 2]    = fb_q[gi];
            assign secret_flat[5*gi +: 5] = reveal ? secret_q[gi] : 5'd0;
        end
    endgenerate

    assign entry_pos   = entry_pos_q;
    assign guess_count = guess_count_q;
    assign busy        = (state_q == S_SCORE_EXACT) || (state_q == S_SCORE_PRESENT);
    assign bad_letter  = bad_q;
    assign win         = (state_q == S_WIN);
    assign lose        = (state_q == S_LOSE);

endmodule

// File: tb/tb_wordle_engine.sv
// Directed bench for wordle_engine: reset, selection, duplicate scoring,
// win, loss and input-robustness scenarios with hand-computed expectations.
module tb_wordle_engine;
    import wordle_pkg::*;

    localparam int WL = 4;
    localparam int MG = 6;
    localparam int NW = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enter = 1'b0;
    logic [4:0]  letter_in = 5'd0;
    logic        word_force = 1'b0;
    logic [4:0]  word_force_idx = 5'd0;
    logic [19:0] guess_flat;
    logic [2:0]  entry_pos;
    logic [7:0]  feedback;
    logic [3:0]  guess_count;
    logic        busy, bad_letter, win, lose;
    logic [19:0] secret_flat;

    int n_checks = 0;
    int n_fail   = 0;

    wordle_engine #(
        .WORD_LEN    (WL),
        .MAX_GUESSES (MG),
        .NUM_WORDS   (NW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enter          (enter),
        .letter_in      (letter_in),
        .word_force     (word_force),
        .word_force_idx (word_force_idx),
        .guess_flat     (guess_flat),
        .entry_pos      (entry_pos),
        .feedback       (feedback),
        .guess_count    (guess_count),
        .busy           (busy),
        .bad_letter     (bad_letter),
        .win            (win),
        .lose           (lose),
        .secret_flat    (secret_flat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [4:0] l);
        @(negedge clk);
        letter_in = l;
        enter     = 1'b1;
        @(negedge clk);
        enter     = 1'b0;
    endtask

    // Enters four letters and waits until scoring has finished (state CHECK).
    task automatic guess4(input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] c, input logic [4:0] d);
        strobe(a);
        strobe(b);
        strobe(c);
        strobe(d);
        repeat (5) @(negedge clk);
        $display("guess %0d %0d %0d %0d -> feedback %b", a, b, c, d, feedback);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_guess",  32'(guess_flat), 32'd0);
        check("rst_pos",    32'(entry_pos), 32'd0);
        check("rst_fb",     32'(feedback), 32'd0);
        check("rst_gc",     32'(guess_count), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_bad",    32'(bad_letter), 32'd0);
        check("rst_win",    32'(win), 32'd0);
        check("rst_lose",   32'(lose), 32'd0);
        check("rst_secret", 32'(secret_flat), 32'd0);
        reset = 1'b0;

        // Start a game, enter two letters, then reset mid-entry
        word_force     = 1'b1;
        word_force_idx = 5'd3;
        strobe(LETTER_Z);
        check("start_state", 32'(dut.state_q), 32'(S_ENTRY));
        strobe(LETTER_A);
        strobe(LETTER_B);
        check("two_pos",   32'(entry_pos), 32'd2);
        check("two_guess", 32'(guess_flat), 32'h00020);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_pos",   32'(entry_pos), 32'd0);
        check("async_guess", 32'(guess_flat), 32'd0);
        @(negedge clk);
        check("mid_rst_state", 32'(dut.state_q), 32'(S_IDLE));
        check("mid_rst_gc",    32'(guess_count), 32'd0);
        reset = 1'b0;

        // New game with secret BOOK
        strobe(LETTER_A);
        check("book_state", 32'(dut.state_q), 32'(S_ENTRY));
        check("book_pos",   32'(entry_pos), 32'd0);

        // Invalid letter
        @(negedge clk);
        letter_in = 5'd27;
        enter     = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        check("bad_pulse", 32'(bad_letter), 32'd1);
        check("bad_pos",   32'(entry_pos), 32'd0);
        @(negedge clk);
        check("bad_end",   32'(bad_letter), 32'd0);

        // Enter held 10 cycles commits exactly one letter
        letter_in = LETTER_O;
        enter     = 1'b1;
        repeat (10) @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        check("held_pos",    32'(entry_pos), 32'd1);
        check("held_letter", 32'(guess_flat[4:0]), 32'(LETTER_O));

        // Guess O,B,O,E with a strobe dropped during SCORE_PRESENT
        strobe(LETTER_B);
        strobe(LETTER_O);
        strobe(LETTER_E);
        check("busy_exact", 32'(busy), 32'd1);
        @(negedge clk);
        letter_in = LETTER_A;
        enter     = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        check("drop_pos",   32'(entry_pos), 32'd4);
        check("drop_state", 32'(dut.state_q), 32'(S_SCORE_PRESENT));
        repeat (3) @(negedge clk);
        $display("guess O B O E -> feedback %b", feedback);
        check("obe_fb",    32'(feedback), 32'h7A);
        check("obe_check", 32'(dut.state_q), 32'(S_CHECK));
        @(negedge clk);
        check("obe_gc",     32'(guess_count), 32'd1);
        check("obe_pos",    32'(entry_pos), 32'd0);
        check("obe_retain", 32'(feedback), 32'h7A);
        check("obe_win",    32'(win), 32'd0);

        // Excess duplicates: O,O,O,O
        strobe(LETTER_O);
        check("fb_cleared", 32'(feedback), 32'd0);
        strobe(LETTER_O);
        strobe(LETTER_O);
        strobe(LETTER_O);
        repeat (5) @(negedge clk);
        $display("guess O O O O -> feedback %b", feedback);
        check("oooo_fb", 32'(feedback), 32'h7D);
        @(negedge clk);
        check("oooo_gc", 32'(guess_count), 32'd2);

        // Win with B,O,O,K
        guess4(LETTER_B, LETTER_O, LETTER_O, LETTER_K);
        check("win_fb", 32'(feedback), 32'hFF);
        @(negedge clk);
        check("win_flag",   32'(win), 32'd1);
        check("win_lose",   32'(lose), 32'd0);
        check("win_gc",     32'(guess_count), 32'd3);
        check("win_secret", 32'(secret_flat), 32'({5'd10, 5'd14, 5'd14, 5'd1}));
        strobe(LETTER_Q);
        check("win_clr_state",  32'(dut.state_q), 32'(S_IDLE));
        check("win_clr_win",    32'(win), 32'd0);
        check("win_clr_guess",  32'(guess_flat), 32'd0);
        check("win_clr_fb",     32'(feedback), 32'd0);
        check("win_clr_gc",     32'(guess_count), 32'd0);
        check("win_clr_secret", 32'(secret_flat), 32'd0);

        // Loss: index 21 wraps to 1 (LOVE), six all-absent guesses
        word_force_idx = 5'd21;
        strobe(LETTER_A);
        for (int g = 1; g <= MG; g++) begin
            guess4(LETTER_A, LETTER_A, LETTER_A, LETTER_A);
            check("loss_fb", 32'(feedback), 32'h55);
            @(negedge clk);
            check("loss_gc",   32'(guess_count), 32'(g));
            check("loss_flag", 32'(lose), 32'(g == MG));
        end
        check("loss_win",    32'(win), 32'd0);
        check("loss_secret", 32'(secret_flat), 32'({5'd4, 5'd21, 5'd14, 5'd11}));
        check("loss_pos",    32'(entry_pos), 32'd4);
        strobe(LETTER_C);
        check("loss_clr_lose",  32'(lose), 32'd0);
        check("loss_clr_gc",    32'(guess_count), 32'd0);
        check("loss_clr_guess", 32'(guess_flat), 32'd0);
        check("loss_clr_pos",   32'(entry_pos), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
